if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
//   Owns the PC and runs the req/ack handshake to instruction memory.
//   Produces if_pc/if_pc4/if_inst/if_have_inst, which IF/ID latches every cycle.
//   Handles hazard stalls and branch/jump redirects, discarding stale fetches.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   NOP_INST  32'h0000_0000  if_inst value driven whenever if_have_inst=0
// PORTS
//   clk_i         in   1   clock, rising edge
//   rst_n_i       in   1   reset, asynchronous, active-low
//   stall_i       in   1   ID/hazard unit: hold the presented instruction
//   redirect_i    in   1   branch/jump taken: refetch from redirect_pc_i
//   redirect_pc_i in   32  redirect target
//   imem_req      out  1   fetch request
//   imem_addr     out  32  fetch address (= pc, or the dropped address in S_DROP)
//   imem_ack      in   1   rdata valid this cycle; response to the current request
//   imem_rdata    in   32  instruction word
//   if_pc         out  32  PC of the presented instruction
//   if_pc4        out  32  if_pc + 4, mod 2^32
//   if_inst       out  32  instruction word, NOP_INST when none
//   if_have_inst  out  1   if_inst is valid
//   if_misalign   out  1   sticky: last redirect target had bits [1:0] != 0
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, state=S_BOOT, hold buffer=NOP_INST, drop target=0.
//     Outputs: imem_req=0, if_have_inst=0, if_inst=NOP_INST, if_misalign=0.
//   States:
//   - S_BOOT: one cycle after reset release, no request, then go to S_FETCH.
//       redirect_i here loads pc.
//   - S_FETCH: imem_req=1, imem_addr=pc. Priority order:
//       1. redirect_i: rdata discarded, if_have_inst=0.
//          With ack: pc<=target, stay in S_FETCH.
//          Without ack: target->drop reg, go to S_DROP.
//       2. ack && !stall_i: if_have_inst=1, if_inst=imem_rdata (combinational).
//          pc<=pc+4. Gives 1 inst/cycle with zero-wait memory.
//       3. ack && stall_i: rdata->hold buffer, if_have_inst=1, go to S_HOLD.
//       4. no ack: if_have_inst=0, if_inst=NOP_INST.
//          imem_addr must stay stable while req && !ack.
//   - S_HOLD: imem_req=0; if_have_inst=1, if_inst=hold buffer, if_pc=pc, all stable.
//       redirect_i: pc<=target, to S_FETCH, if_have_inst=0 that cycle.
//       else !stall_i: pc<=pc+4, to S_FETCH.
//   - S_DROP: imem_req=1, imem_addr=stale pc, if_have_inst=0.
//       On ack: discard rdata, pc<=drop target, to S_FETCH.
//       A new redirect_i here overwrites the drop target (last one wins).
//   if_pc=pc and if_pc4=pc+4 in every state. 0xFFFF_FFFC+4 wraps to 0.
//   redirect_i beats stall_i when both are asserted.
//   Reset mid-transaction: the fetch is abandoned and any late ack after reset is
//     ignored (state is S_BOOT).
// CONFIGURATION
//   IF_ALIGN_CHECK_EN defined:
//     pc loads {redirect_pc_i[31:2],2'b00}.
//     if_misalign <= |redirect_pc_i[1:0] on every accepted redirect; holds otherwise.
//   IF_ALIGN_CHECK_EN undefined:
//     pc loads redirect_pc_i verbatim; if_misalign tied 0.
// TESTING
//   1. Zero-wait memory (ack held 1), no stall, RESET_PC=0 -> after S_BOOT:
//      if_pc 0,4,8,... one per cycle, if_have_inst=1, if_inst=mem[pc].
//   2. ack 2 cycles late at pc=0x10 -> if_have_inst=0 for 2 cycles,
//      imem_addr stays 0x10, then inst valid with if_pc4=0x14.
//   3. stall_i 3 cycles over ack at pc=0x20 -> if_pc=0x20 and if_inst held 3 cycles,
//      imem_req=0; pc=0x24 fetched the cycle after release.
//   4. redirect_i to 0x100 with ack pending at 0x30 -> addr held 0x30 until ack,
//      that data dropped (if_have_inst=0), next fetch addr 0x100.
//   5. redirect_i and stall_i together in S_HOLD -> pc=target,
//      if_have_inst=0 that cycle, no stale instruction presented.
//   6. IF_ALIGN_CHECK_EN, redirect to 0x102 -> imem_addr 0x100, if_misalign=1;
//      next redirect to 0x200 clears it. pc=0xFFFF_FFFC -> if_pc4=0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, handles stalls/redirects.
// Optional IF_ALIGN_CHECK_EN: word-align redirect targets and flag misaligned ones on if_misalign.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_pc4,
  output logic [31:0]            if_inst,
  output logic                   if_have_inst,
  output logic                   if_misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   hold_q, hold_d;
  logic [XLEN-1:0]   drop_q, drop_d;
  logic [XLEN-1:0]   redir_tgt;
  logic              req_c;
  logic              have_c;
  logic [XLEN-1:0]   inst_c;

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q;

  assign redir_tgt = {redirect_pc_i[31:2], 2'b00};

  // Every state accepts a redirect, so the flag simply tracks the latest one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      misalign_q <= |redirect_pc_i[1:0];
    end
  end

  assign if_misalign = misalign_q;
`else
  assign redir_tgt   = redirect_pc_i;
  assign if_misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INST;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and presentation logic; redirect always wins over stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    drop_d  = drop_q;
    req_c   = 1'b0;
    have_c  = 1'b0;
    inst_c  = NOP_INST;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (redirect_i) pc_d = redir_tgt;
      end

      S_FETCH: begin
        req_c = 1'b1;
        if (redirect_i) begin
          if (imem.imem_ack) begin
            pc_d = redir_tgt;
          end else begin
            // Outstanding request must complete at the old address before refetching.
            drop_d  = redir_tgt;
            state_d = S_DROP;
          end
        end else if (imem.imem_ack) begin
          have_c = 1'b1;
          inst_c = imem.imem_rdata;
          if (stall_i) begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redir_tgt;
          state_d = S_FETCH;
        end else begin
          have_c = 1'b1;
          inst_c = hold_q;
          if (!stall_i) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_FETCH;
          end
        end
      end

      S_DROP: begin
        req_c = 1'b1;
        if (redirect_i) drop_d = redir_tgt;
        if (imem.imem_ack) begin
          state_d = S_FETCH;
          pc_d    = redirect_i ? redir_tgt : drop_q;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  // pc_q only moves on ack/redirect/hold-release, so the address is stable while req && !ack.
  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc_q;
  assign if_pc          = pc_q;
  assign if_pc4         = pc_q + XLEN'(4);
  assign if_inst        = inst_c;
  assign if_have_inst   = have_c;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes expected instructions, a monitor pops them.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack_r = 1'b0;
  logic        stall_r = 1'b0;
  logic        redir_r = 1'b0;
  logic [31:0] rpc_r = 32'h0;
  logic        corrupt = 1'b0;

  logic [31:0] d_pc, d_pc4, d_inst;
  logic        d_have, d_mis;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

`ifdef IF_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_102 = 32'h0000_0100;
  localparam logic [31:0] EXP_MIS = 32'h1;
`else
  localparam logic [31:0] EXP_102 = 32'h0000_0102;
  localparam logic [31:0] EXP_MIS = 32'h0;
`endif

  if_fetch_unit_if bus();

  // Zero-wait memory image: word at address A is {16'hC0DE, A[15:0]}; corrupt scrambles it.
  assign bus.imem_ack   = ack_r;
  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]} ^ (corrupt ? 32'hFFFF_FFFF : 32'h0);

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall_r),
    .redirect_i    (redir_r),
    .redirect_pc_i (rpc_r),
    .imem          (bus),
    .if_pc         (d_pc),
    .if_pc4        (d_pc4),
    .if_inst       (d_inst),
    .if_have_inst  (d_have),
    .if_misalign   (d_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; an expected instruction is queued when exp_v is set.
  task automatic cyc(input logic ack, input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic cor, input logic exp_v, input logic [31:0] exp_pc);
    exp_t e;
    @(posedge clk);
    #1;
    ack_r   = ack;
    stall_r = stall;
    redir_r = redir;
    rpc_r   = rpc;
    corrupt = cor;
    if (exp_v) begin
      e.pc   = exp_pc;
      e.pc4  = exp_pc + 32'd4;
      e.inst = {16'hC0DE, exp_pc[15:0]};
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("have_inst", {31'b0, d_have}, {31'b0, exp_v});
    if (!exp_v) chk("nop_inst", d_inst, 32'h0);
  endtask

  // Monitor: every presented instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && d_have) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst actual_pc=%h required=none", d_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_pc", d_pc, e.pc);
        chk("mon_pc4", d_pc4, e.pc4);
        chk("mon_inst", d_inst, e.inst);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_have", {31'b0, d_have}, 32'h0);
    chk("rst_inst", d_inst, 32'h0);
    chk("rst_mis", {31'b0, d_mis}, 32'h0);
    chk("rst_pc", d_pc, 32'h0);
    chk("rst_pc4", d_pc4, 32'h4);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_r = 1'b1;
    @(negedge clk);
    chk("boot_req", {31'b0, bus.imem_req}, 32'h0);
    chk("boot_have", {31'b0, d_have}, 32'h0);

    // Zero-wait streaming, one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4));
      chk("t1_addr", bus.imem_addr, 32'(i * 4));
      chk("t1_req", {31'b0, bus.imem_req}, 32'h1);
    end

    // Two-cycle late ack at 0x10.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t2_addr0", bus.imem_addr, 32'h10);
    chk("t2_req0", {31'b0, bus.imem_req}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t2_addr1", bus.imem_addr, 32'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
    chk("t2_pc4", d_pc4, 32'h14);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'(32'h14 + i * 4));

    // Stall over an ack at 0x20; memory data is scrambled while holding.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
    chk("t3_req_b", {31'b0, bus.imem_req}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
    chk("t3_req_c", {31'b0, bus.imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
    chk("t3_req_d", {31'b0, bus.imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h24);
    chk("t3_addr", bus.imem_addr, 32'h24);
    chk("t3_req_e", {31'b0, bus.imem_req}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h28);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2C);

    // Redirect to 0x100 with the 0x30 fetch still pending.
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("t4_addr_f", bus.imem_addr, 32'h30);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t4_addr_g", bus.imem_addr, 32'h30);
    chk("t4_req_g", {31'b0, bus.imem_req}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t4_addr_h", bus.imem_addr, 32'h30);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    chk("t4_addr_i", bus.imem_addr, 32'h100);

    // Redirect coinciding with an ack in fetch.
    cyc(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);

    // Redirect together with stall while holding.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h204);
    cyc(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    chk("t5_req", {31'b0, bus.imem_req}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    chk("t5_addr", bus.imem_addr, 32'h300);

    // Second redirect during drop replaces the first target.
    cyc(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drop_addr", bus.imem_addr, 32'h304);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500);

    // Misaligned redirect target, then an aligned one.
    cyc(1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, EXP_102);
    chk("t6_addr", bus.imem_addr, EXP_102);
    chk("t6_mis_set", {31'b0, d_mis}, EXP_MIS);
    cyc(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    chk("t6_mis_clr", {31'b0, d_mis}, 32'h0);

    // PC wrap at the top of the address space.
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc4", d_pc4, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

    // Reset with a fetch outstanding; the late ack must be ignored in boot.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ack_r = 1'b1;
    #2;
    chk("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("mid_rst_pc", d_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_boot_req", {31'b0, bus.imem_req}, 32'h0);
    chk("mid_boot_have", {31'b0, d_have}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
